cvxif_copro_scoreboard: RTL and testbench
=========================================

# cvxif_copro_scoreboard

Parametrised CV-X-IF coprocessor execution unit. It holds up to DEPTH issued instructions in flight, tracks each one through commit or kill, and runs them with a configurable execution latency. Results return to the core through a valid/ready result channel, in order or out of order. It sits behind the coprocessor instruction decoder and replaces the single-path add/max example datapath with a multi-entry scoreboard, an op select and result backpressure.

## Interface
- XLEN, 64: operand and result width.
- ID_WIDTH, 3: width of the CV-X-IF instruction ID.
- DEPTH, 4: number of in-flight entries; power of two, at least 2.
- LATENCY, 2: cycles an entry spends executing after commit; range 0..15.
- IN_ORDER, 1: 1 = results return in issue order; 0 = results return in any order.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  at least one entry is free.
- issue_accept_i  in  1  decoder accepted the instruction; only accepted instructions are stored.
- issue_id_i  in  ID_WIDTH  instruction ID.
- issue_op_i  in  2  operation: 00 = rs1+rs2, 01 = unsigned max(rs1,rs2), 10 = unsigned min(rs1,rs2), 11 = rs1+rs2+rs3.
- issue_rs_i  in  3*XLEN  operands; rs1 in bits [XLEN-1:0], then rs2, then rs3.
- issue_rd_i  in  5  destination register.
- issue_we_i  in  1  writeback requested.
- commit_valid_i  in  1  commit or kill strobe.
- commit_id_i  in  ID_WIDTH  ID being committed or killed.
- commit_kill_i  in  1  1 = discard the instruction.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  core accepts the result.
- result_id_o  out  ID_WIDTH  result ID.
- result_rd_o  out  5  result destination register.
- result_data_o  out  XLEN  result data.
- result_we_o  out  1  stored issue_we_i, gated by result_valid_o.
- result_exc_o  out  1  constant 0.
- occupancy_o  out  $clog2(DEPTH+1)  number of non-FREE entries.

## Operation
- Each entry has its own FSM with states FREE, WAIT_COMMIT, EXEC and DONE.
- **Issue** fires when issue_valid_i && issue_ready_o && issue_accept_i.
  - The lowest-index FREE entry is allocated.
  - The result is computed at issue and stored along with ID, rd and we. Operands are not retained.
  - Arithmetic wraps modulo 2^XLEN; comparisons are unsigned.
- **Commit** (commit_valid_i) matches the entry in WAIT_COMMIT whose ID equals commit_id_i.
  - Kill: the entry returns to FREE.
  - No kill: the entry moves to EXEC with its counter loaded to LATENCY. With LATENCY = 0 it moves directly to DONE.
  - A commit with no matching entry (unknown ID, or entry already committed) is ignored.
- **Same-cycle issue and commit:** if commit_id_i equals issue_id_i in the cycle the instruction is issued, the commit applies to the new entry. It is written straight to EXEC or DONE, or not allocated at all if killed.
- **EXEC:** the counter decrements every cycle; the entry moves to DONE when it reaches 1. An entry therefore spends exactly LATENCY cycles in EXEC.
- **Result selection:**
  - IN_ORDER = 1: the oldest non-FREE entry, by allocation order, is presented only when it is DONE. Killed entries drop out of the age order.
  - IN_ORDER = 0: the lowest-index DONE entry is presented.
  - Once result_valid_o is high, the selection is locked until the handshake completes. A newly DONE entry never preempts the presented one.
- **Retire:** on result_valid_o && result_ready_i, the presented entry returns to FREE.
- **Protocol rule on the core:** at most one in-flight instruction per ID. Behaviour with duplicate IDs is undefined.

## Timing
- **Reset values:**
  - All entries FREE.
  - issue_ready_o = 1, occupancy_o = 0.
  - result_valid_o = 0; result_id_o, result_rd_o, result_data_o and result_we_o = 0; result_exc_o = 0.
  - Reset asserted mid-operation discards all entries immediately and drops result_valid_o in the same cycle.
- **issue_ready_o** is decoded from registered entry state only.
  - An entry freed at clock edge e is allocatable in the cycle after e.
  - With all entries busy, issue_ready_o is low. It goes high the cycle after a kill or retire.
- **Latency:** commit in cycle c gives result_valid_o in cycle c+1+LATENCY at the earliest. With LATENCY = 0 that is cycle c+1.
- **result_valid_o** is driven from registered state; result_ready_i is never combinationally required.
- While result_valid_o && !result_ready_i, all result outputs stay stable.
- One issue, one commit and one retire may occur in the same cycle; occupancy_o reflects the net effect at the next edge.

## Test plan
- Reset, LATENCY=2; issue id 2, op 00, rs1=5, rs2=7, rd=10, we=1; commit at c -> result_valid_o at c+3 with id 2, data 12, rd 10, we 1; occupancy_o returns to 0 after the handshake.
- DEPTH=4, issue ids 0-3 with no commit -> issue_ready_o=0, occupancy_o=4; kill id 1 -> issue_ready_o=1 the next cycle; no result for id 1 ever appears.
- IN_ORDER=1: issue ids 0 and 1, commit 1 then 0 -> results appear as id 0 then id 1. Same sequence with IN_ORDER=0 -> id 1 appears first.
- Hold result_ready_i low for 5 cycles while two entries are DONE -> valid and payload stay stable, no result is lost; both results return when ready goes high.
- Arithmetic: op 00, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=2 -> data 1. op 01 with rs1=all-ones, rs2=1 -> all-ones. op 10 with the same operands -> 1. op 11 with rs1=1, rs2=2, rs3=3 -> 6.
- Boundary conditions:
  - Commit on an unknown ID -> no state change.
  - Issue and commit of the same ID in the same cycle with LATENCY=0 -> result valid the next cycle.
  - Reset asserted with 3 entries busy -> all outputs return to their reset values.

Source files
------------

// File: rtl/cvxif_copro_scoreboard.sv
// CV-X-IF coprocessor execution unit: DEPTH-entry scoreboard with commit/kill tracking,
// fixed execution latency and in-order or out-of-order result return under backpressure.
module cvxif_copro_scoreboard #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LATENCY  = 2,
  parameter bit          IN_ORDER = 1'b1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic                       issue_accept_i,
  input  logic [ID_WIDTH-1:0]        issue_id_i,
  input  logic [1:0]                 issue_op_i,
  input  logic [3*XLEN-1:0]          issue_rs_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       issue_we_i,
  input  logic                       commit_valid_i,
  input  logic [ID_WIDTH-1:0]        commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [ID_WIDTH-1:0]        result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic [XLEN-1:0]            result_data_o,
  output logic                       result_we_o,
  output logic                       result_exc_o,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH+1);
  localparam logic [3:0]  LAT4 = 4'(LATENCY);

  typedef enum logic [1:0] {FREE, WAIT_COMMIT, EXEC, DONE} state_e;

  state_e          st_q   [DEPTH];
  state_e          st_d   [DEPTH];
  logic [3:0]      cnt_q  [DEPTH];
  logic [3:0]      cnt_d  [DEPTH];
  // age = number of older live entries; 0 marks the oldest
  logic [IW-1:0]   age_q  [DEPTH];
  logic [IW-1:0]   age_d  [DEPTH];
  logic [ID_WIDTH-1:0] id_q [DEPTH];
  logic [4:0]      rd_q   [DEPTH];
  logic            we_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];

  logic            lock_q, lock_d;
  logic [IW-1:0]   lock_idx_q, lock_idx_d;

  logic            free_found;
  logic [IW-1:0]   free_idx;
  logic [OW-1:0]   occ;
  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic            res_vld;
  logic [IW-1:0]   res_idx;
  logic            retire;
  logic            issue_fire, same_commit, alloc;
  logic [DEPTH-1:0] freed;
  logic [OW-1:0]   keep_cnt;

  function automatic logic [XLEN-1:0] op_result(input logic [1:0] op,
                                                input logic [3*XLEN-1:0] rs);
    logic [XLEN-1:0] a, b, c;
    a = rs[XLEN-1:0];
    b = rs[2*XLEN-1:XLEN];
    c = rs[3*XLEN-1:2*XLEN];
    case (op)
      2'b00:   return a + b;
      2'b01:   return (a > b) ? a : b;
      2'b10:   return (a < b) ? a : b;
      default: return a + b + c;
    endcase
  endfunction

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    occ        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] == FREE) begin
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IW'(i);
        end
      end else begin
        occ = occ + 1'b1;
      end
    end
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!pick_found && st_q[i] == DONE && (!IN_ORDER || age_q[i] == '0)) begin
        pick_found = 1'b1;
        pick_idx   = IW'(i);
      end
    end
  end

  // a presented result stays selected until the core takes it
  assign res_vld    = lock_q | pick_found;
  assign res_idx    = lock_q ? lock_idx_q : pick_idx;
  assign retire     = res_vld & result_ready_i;
  assign lock_d     = res_vld & ~result_ready_i;
  assign lock_idx_d = res_idx;

  assign issue_fire  = issue_valid_i & free_found & issue_accept_i;
  assign same_commit = issue_fire & commit_valid_i & (commit_id_i == issue_id_i);
  assign alloc       = issue_fire & ~(same_commit & commit_kill_i);

  always_comb begin
    freed    = '0;
    keep_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      age_d[i] = age_q[i];
      case (st_q[i])
        WAIT_COMMIT: begin
          if (commit_valid_i && commit_id_i == id_q[i]) begin
            if (commit_kill_i) begin
              st_d[i]  = FREE;
              freed[i] = 1'b1;
            end else if (LATENCY == 0) begin
              st_d[i] = DONE;
            end else begin
              st_d[i]  = EXEC;
              cnt_d[i] = LAT4;
            end
          end
        end
        EXEC: begin
          cnt_d[i] = cnt_q[i] - 1'b1;
          if (cnt_q[i] == 4'd1) st_d[i] = DONE;
        end
        DONE: begin
          if (retire && res_idx == IW'(i)) begin
            st_d[i]  = FREE;
            freed[i] = 1'b1;
          end
        end
        default: ;
      endcase
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (st_q[i] != FREE && !freed[i]) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (freed[j] && age_q[j] < age_q[i]) age_d[i] = age_d[i] - 1'b1;
        end
        keep_cnt = keep_cnt + 1'b1;
      end
    end
    if (alloc) begin
      st_d[free_idx]  = !same_commit ? WAIT_COMMIT : ((LATENCY == 0) ? DONE : EXEC);
      cnt_d[free_idx] = LAT4;
      age_d[free_idx] = keep_cnt[IW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= FREE;
        cnt_q[i] <= '0;
        age_q[i] <= '0;
      end
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
        age_q[i] <= age_d[i];
      end
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // payload is only observed through a live entry, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (alloc) begin
      id_q[free_idx]   <= issue_id_i;
      rd_q[free_idx]   <= issue_rd_i;
      we_q[free_idx]   <= issue_we_i;
      data_q[free_idx] <= op_result(issue_op_i, issue_rs_i);
    end
  end

  assign issue_ready_o  = free_found;
  assign occupancy_o    = occ;
  assign result_valid_o = res_vld;
  assign result_id_o    = res_vld ? id_q[res_idx]   : '0;
  assign result_rd_o    = res_vld ? rd_q[res_idx]   : '0;
  assign result_data_o  = res_vld ? data_q[res_idx] : '0;
  assign result_we_o    = res_vld & we_q[res_idx];
  assign result_exc_o   = 1'b0;

endmodule

// File: tb/tb_cvxif_copro_scoreboard.sv
// Bench for cvxif_copro_scoreboard: instance A (LATENCY=2, in order) and instance B
// (LATENCY=0, out of order) checked against a slot/queue model every cycle plus literals.
module tb_cvxif_copro_scoreboard;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         iv [2], ia [2], cv [2], ck [2], rdy [2], iwe [2];
  logic [2:0]   iid [2], cid [2];
  logic [1:0]   iop [2];
  logic [191:0] irs [2];
  logic [4:0]   ird [2];

  logic         iready [2], rvalid [2], rwe [2], rexc [2];
  logic [2:0]   rid [2], occ [2];
  logic [4:0]   rrd [2];
  logic [63:0]  rdata [2];

  cvxif_copro_scoreboard #(.XLEN(64), .ID_WIDTH(3), .DEPTH(DEPTH), .LATENCY(2), .IN_ORDER(1'b1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(iv[0]), .issue_ready_o(iready[0]), .issue_accept_i(ia[0]),
    .issue_id_i(iid[0]), .issue_op_i(iop[0]), .issue_rs_i(irs[0]), .issue_rd_i(ird[0]),
    .issue_we_i(iwe[0]), .commit_valid_i(cv[0]), .commit_id_i(cid[0]), .commit_kill_i(ck[0]),
    .result_valid_o(rvalid[0]), .result_ready_i(rdy[0]), .result_id_o(rid[0]),
    .result_rd_o(rrd[0]), .result_data_o(rdata[0]), .result_we_o(rwe[0]),
    .result_exc_o(rexc[0]), .occupancy_o(occ[0]));

  cvxif_copro_scoreboard #(.XLEN(64), .ID_WIDTH(3), .DEPTH(DEPTH), .LATENCY(0), .IN_ORDER(1'b0)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(iv[1]), .issue_ready_o(iready[1]), .issue_accept_i(ia[1]),
    .issue_id_i(iid[1]), .issue_op_i(iop[1]), .issue_rs_i(irs[1]), .issue_rd_i(ird[1]),
    .issue_we_i(iwe[1]), .commit_valid_i(cv[1]), .commit_id_i(cid[1]), .commit_kill_i(ck[1]),
    .result_valid_o(rvalid[1]), .result_ready_i(rdy[1]), .result_id_o(rid[1]),
    .result_rd_o(rrd[1]), .result_data_o(rdata[1]), .result_we_o(rwe[1]),
    .result_exc_o(rexc[1]), .occupancy_o(occ[1]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input int k, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%0h exp=%0h", n, k, act, exp);
    end
  endtask

  // ---------------- model: slots with allocation sequence numbers ----------------
  bit          m_busy [2][DEPTH];
  int          m_ph   [2][DEPTH];   // 0 awaiting commit, 1 executing, 2 finished
  int          m_rem  [2][DEPTH];
  longint      m_seq  [2][DEPTH];
  logic [2:0]  m_id   [2][DEPTH];
  logic [4:0]  m_rd   [2][DEPTH];
  logic        m_we   [2][DEPTH];
  logic [63:0] m_data [2][DEPTH];
  bit          m_lock [2];
  int          m_lslot[2];
  longint      m_ctr  [2];

  function automatic int lat(input int k);
    return (k == 0) ? 2 : 0;
  endfunction

  function automatic logic [63:0] calc(input logic [1:0] op, input logic [191:0] rs);
    logic [63:0] a, b, c;
    a = rs[63:0]; b = rs[127:64]; c = rs[191:128];
    if (op == 2'd0) return a + b;
    if (op == 2'd1) return (a > b) ? a : b;
    if (op == 2'd2) return (a < b) ? a : b;
    return a + b + c;
  endfunction

  function automatic void pres(input int k, output bit v, output int s);
    int o;
    o = -1; v = 1'b0; s = 0;
    if (m_lock[k]) begin
      v = 1'b1; s = m_lslot[k];
    end else if (k == 0) begin
      for (int i = 0; i < DEPTH; i++)
        if (m_busy[k][i] && (o < 0 || m_seq[k][i] < m_seq[k][o])) o = i;
      if (o >= 0 && m_ph[k][o] == 2) begin v = 1'b1; s = o; end
    end else begin
      for (int i = DEPTH-1; i >= 0; i--)
        if (m_busy[k][i] && m_ph[k][i] == 2) begin v = 1'b1; s = i; end
    end
  endfunction

  function automatic void model_step(input int k);
    bit v; int s; int fs; bit hit;
    pres(k, v, s);
    fs = -1;
    for (int i = 0; i < DEPTH; i++) if (!m_busy[k][i] && fs < 0) fs = i;
    if (v && rdy[k]) m_busy[k][s] = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (m_busy[k][i] && m_ph[k][i] == 1) begin
        if (m_rem[k][i] == 1) m_ph[k][i] = 2; else m_rem[k][i]--;
      end
    if (cv[k])
      for (int i = 0; i < DEPTH; i++)
        if (m_busy[k][i] && m_ph[k][i] == 0 && m_id[k][i] == cid[k]) begin
          if (ck[k]) m_busy[k][i] = 1'b0;
          else if (lat(k) == 0) m_ph[k][i] = 2;
          else begin m_ph[k][i] = 1; m_rem[k][i] = lat(k); end
        end
    if (iv[k] && ia[k] && fs >= 0) begin
      hit = cv[k] && (cid[k] == iid[k]);
      if (!(hit && ck[k])) begin
        m_busy[k][fs] = 1'b1;
        m_ph[k][fs]   = !hit ? 0 : ((lat(k) == 0) ? 2 : 1);
        m_rem[k][fs]  = lat(k);
        m_seq[k][fs]  = m_ctr[k];
        m_ctr[k]++;
        m_id[k][fs]   = iid[k];
        m_rd[k][fs]   = ird[k];
        m_we[k][fs]   = iwe[k];
        m_data[k][fs] = calc(iop[k], irs[k]);
      end
    end
    m_lock[k]  = v && !rdy[k];
    m_lslot[k] = s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < DEPTH; i++) m_busy[k][i] = 1'b0;
        m_lock[k] = 1'b0; m_lslot[k] = 0; m_ctr[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  bit cmp_v; int cmp_s; int cmp_occ;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        pres(k, cmp_v, cmp_s);
        cmp_occ = 0;
        for (int i = 0; i < DEPTH; i++) if (m_busy[k][i]) cmp_occ++;
        chk("cmp_valid", k, rvalid[k], cmp_v);
        chk("cmp_id",    k, rid[k],   cmp_v ? m_id[k][cmp_s]   : 3'd0);
        chk("cmp_rd",    k, rrd[k],   cmp_v ? m_rd[k][cmp_s]   : 5'd0);
        chk("cmp_data",  k, rdata[k], cmp_v ? m_data[k][cmp_s] : 64'd0);
        chk("cmp_we",    k, rwe[k],   cmp_v ? m_we[k][cmp_s]   : 1'b0);
        chk("cmp_exc",   k, rexc[k],  0);
        chk("cmp_ready", k, iready[k], cmp_occ < DEPTH);
        chk("cmp_occ",   k, occ[k],   cmp_occ);
      end
    end
  end

  // ---------------- retired-result monitor ----------------
  typedef struct packed { logic [2:0] id; logic [4:0] rd; logic we; logic [63:0] data; } ret_t;
  ret_t ret0[$];
  ret_t ret1[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (rvalid[0] && rdy[0]) ret0.push_back({rid[0], rrd[0], rwe[0], rdata[0]});
      if (rvalid[1] && rdy[1]) ret1.push_back({rid[1], rrd[1], rwe[1], rdata[1]});
    end
  end

  // ---------------- drivers ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_issue(input bit [1:0] m, input int id, input int op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] c, input int rd, input bit we);
    for (int k = 0; k < 2; k++) if (m[k]) begin
      iv[k] = 1'b1; ia[k] = 1'b1; iid[k] = 3'(id); iop[k] = 2'(op);
      irs[k] = {c, b, a}; ird[k] = 5'(rd); iwe[k] = we;
    end
  endtask

  task automatic issue(input bit [1:0] m, input int id, input int op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] c, input int rd, input bit we);
    set_issue(m, id, op, a, b, c, rd, we);
    cyc();
    for (int k = 0; k < 2; k++) begin iv[k] = 1'b0; ia[k] = 1'b0; end
  endtask

  task automatic commit(input bit [1:0] m, input int id, input bit kill);
    for (int k = 0; k < 2; k++) if (m[k]) begin cv[k] = 1'b1; cid[k] = 3'(id); ck[k] = kill; end
    cyc();
    for (int k = 0; k < 2; k++) begin cv[k] = 1'b0; ck[k] = 1'b0; end
  endtask

  task automatic issue_commit(input bit [1:0] m, input int id, input logic [63:0] a,
                              input logic [63:0] b, input bit kill);
    set_issue(m, id, 0, a, b, 64'd0, id, 1'b1);
    for (int k = 0; k < 2; k++) if (m[k]) begin cv[k] = 1'b1; cid[k] = 3'(id); ck[k] = kill; end
    cyc();
    for (int k = 0; k < 2; k++) begin iv[k] = 1'b0; ia[k] = 1'b0; cv[k] = 1'b0; ck[k] = 1'b0; end
  endtask

  task automatic drain(input bit [1:0] m, input int n0, input int n1);
    int t;
    t = 0;
    for (int k = 0; k < 2; k++) if (m[k]) rdy[k] = 1'b1;
    while ((ret0.size() < n0 || ret1.size() < n1) && t < 50) begin cyc(); t++; end
    chk("drain_bound", 0, t < 50, 1);
    rdy[0] = 1'b0; rdy[1] = 1'b0;
  endtask

  task automatic chk_ret(input int k, input int idx, input int id, input logic [63:0] data);
    ret_t r;
    r = '1;
    if (k == 0 && idx < ret0.size()) r = ret0[idx];
    if (k == 1 && idx < ret1.size()) r = ret1[idx];
    chk("ret_id", k, r.id, id);
    chk("ret_data", k, r.data, data);
  endtask

  task automatic chk_idle(input string n, input int k);
    chk({n, "_valid"}, k, rvalid[k], 0);
    chk({n, "_ready"}, k, iready[k], 1);
    chk({n, "_occ"},   k, occ[k], 0);
    chk({n, "_pay"},   k, {rid[k], rrd[k], rwe[k], rexc[k]}, 0);
    chk({n, "_data"},  k, rdata[k], 0);
  endtask

  logic [63:0] ones;
  logic [2:0]  snap_id [2];
  logic [63:0] snap_dt [2];

  initial begin
    ones = '1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 0; ia[k] = 0; cv[k] = 0; ck[k] = 0; rdy[k] = 0; iwe[k] = 0;
      iid[k] = 0; cid[k] = 0; iop[k] = 0; irs[k] = 0; ird[k] = 0;
    end
    repeat (3) cyc();
    chk_idle("rst", 0); chk_idle("rst", 1);
    rst_n = 1'b1;
    cyc();

    // basic latency path
    issue(2'b01, 2, 0, 64'd5, 64'd7, 64'd0, 10, 1'b1);
    chk("t1_occ", 0, occ[0], 1);
    commit(2'b01, 2, 1'b0);
    chk("t1_c1", 0, rvalid[0], 0); cyc();
    chk("t1_c2", 0, rvalid[0], 0); cyc();
    chk("t1_c3", 0, rvalid[0], 1);
    chk("t1_id", 0, rid[0], 2); chk("t1_data", 0, rdata[0], 12);
    chk("t1_rd", 0, rrd[0], 10); chk("t1_we", 0, rwe[0], 1);
    rdy[0] = 1'b1; cyc(); rdy[0] = 1'b0;
    chk("t1_occ_end", 0, occ[0], 0); chk("t1_v_end", 0, rvalid[0], 0);

    // full, then kill frees a slot
    ret0.delete();
    for (int i = 0; i < 4; i++) issue(2'b01, i, 0, 64'(i), 64'd10, 64'd0, i, 1'b1);
    chk("t2_ready_full", 0, iready[0], 0); chk("t2_occ_full", 0, occ[0], 4);
    commit(2'b01, 1, 1'b1);
    chk("t2_ready_kill", 0, iready[0], 1); chk("t2_occ_kill", 0, occ[0], 3);
    commit(2'b01, 0, 1'b0); commit(2'b01, 2, 1'b0); commit(2'b01, 3, 1'b0);
    drain(2'b01, 3, 0);
    chk("t2_cnt", 0, ret0.size(), 3);
    chk_ret(0, 0, 0, 10); chk_ret(0, 1, 2, 12); chk_ret(0, 2, 3, 13);

    // return order: in order vs out of order
    ret0.delete(); ret1.delete();
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    issue(2'b11, 0, 0, 64'd1, 64'd1, 64'd0, 1, 1'b1);
    issue(2'b11, 1, 0, 64'd2, 64'd2, 64'd0, 2, 1'b1);
    commit(2'b11, 1, 1'b0); commit(2'b11, 0, 1'b0);
    drain(2'b11, 2, 2);
    chk_ret(0, 0, 0, 2); chk_ret(0, 1, 1, 4);
    chk_ret(1, 0, 1, 4); chk_ret(1, 1, 0, 2);

    // backpressure with two finished entries; max/min operations
    ret0.delete(); ret1.delete();
    issue(2'b11, 4, 1, ones, 64'd1, 64'd0, 4, 1'b0);
    issue(2'b11, 5, 2, ones, 64'd1, 64'd0, 5, 1'b1);
    commit(2'b11, 5, 1'b0); commit(2'b11, 4, 1'b0);
    cyc(); cyc();
    chk("t4_v", 0, rvalid[0], 1); chk("t4_id", 0, rid[0], 4);
    chk("t4_data", 0, rdata[0], ones); chk("t4_we", 0, rwe[0], 0);
    chk("t4_v", 1, rvalid[1], 1); chk("t4_id", 1, rid[1], 5); chk("t4_data", 1, rdata[1], 1);
    for (int k = 0; k < 2; k++) begin snap_id[k] = rid[k]; snap_dt[k] = rdata[k]; end
    for (int c = 0; c < 5; c++) begin
      cyc();
      for (int k = 0; k < 2; k++) begin
        chk("t4_hold_v", k, rvalid[k], 1);
        chk("t4_hold_id", k, rid[k], snap_id[k]);
        chk("t4_hold_dt", k, rdata[k], snap_dt[k]);
      end
    end
    drain(2'b11, 2, 2);
    chk_ret(0, 0, 4, ones); chk_ret(0, 1, 5, 1);
    chk_ret(1, 0, 5, 1); chk_ret(1, 1, 4, ones);

    // wrapping add and three-operand add
    ret0.delete(); ret1.delete();
    issue(2'b11, 6, 0, ones, 64'd2, 64'd0, 6, 1'b1);
    issue(2'b11, 7, 3, 64'd1, 64'd2, 64'd3, 7, 1'b1);
    commit(2'b11, 6, 1'b0); commit(2'b11, 7, 1'b0);
    drain(2'b11, 2, 2);
    chk_ret(0, 0, 6, 1); chk_ret(0, 1, 7, 6); chk_ret(1, 0, 6, 1); chk_ret(1, 1, 7, 6);

    // not-accepted issue, unknown and repeated commits
    ret0.delete();
    iv[0] = 1'b1; ia[0] = 1'b0; iid[0] = 3'd3; cyc(); iv[0] = 1'b0;
    chk("t6_noacc", 0, occ[0], 0);
    issue(2'b01, 3, 0, 64'd3, 64'd4, 64'd0, 3, 1'b1);
    commit(2'b01, 6, 1'b0);
    chk("t6_unk_occ", 0, occ[0], 1); chk("t6_unk_v", 0, rvalid[0], 0);
    commit(2'b01, 6, 1'b1);
    chk("t6_unkkill_occ", 0, occ[0], 1);
    commit(2'b01, 3, 1'b0); commit(2'b01, 3, 1'b1);
    chk("t6_dup_occ", 0, occ[0], 1);
    cyc();
    chk("t6_v", 0, rvalid[0], 1); chk("t6_id", 0, rid[0], 3); chk("t6_data", 0, rdata[0], 7);
    drain(2'b01, 1, 0);

    // same-cycle issue and commit / kill
    ret0.delete(); ret1.delete();
    issue_commit(2'b11, 2, 64'd20, 64'd22, 1'b0);
    chk("t7_v", 1, rvalid[1], 1); chk("t7_id", 1, rid[1], 2); chk("t7_data", 1, rdata[1], 42);
    chk("t7_v1", 0, rvalid[0], 0); cyc();
    chk("t7_v2", 0, rvalid[0], 0); cyc();
    chk("t7_v3", 0, rvalid[0], 1); chk("t7_data", 0, rdata[0], 42);
    drain(2'b11, 1, 1);
    issue_commit(2'b11, 5, 64'd1, 64'd1, 1'b1);
    chk("t7_kill_occ", 0, occ[0], 0); chk("t7_kill_occ", 1, occ[1], 0);

    // asynchronous reset with three entries busy
    for (int i = 0; i < 3; i++) issue(2'b11, i, 0, 64'(i), 64'd1, 64'd0, i, 1'b1);
    commit(2'b10, 0, 1'b0);
    chk("t8_v", 1, rvalid[1], 1); chk("t8_occ", 0, occ[0], 3); chk("t8_occ", 1, occ[1], 3);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("t8_async", 0); chk_idle("t8_async", 1);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    chk_idle("t8_after", 0); chk_idle("t8_after", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
